fm_phase_discriminator: RTL and testbench

Parametrised FM discriminator that takes a stream of phase angles (CORDIC output) and produces the signed phase difference between consecutive samples. Wrap-around is resolved by modular two's-complement subtraction. An integrate-and-dump decimator averages 2^DECIM_LOG2 differences per output sample. It sits between the CORDIC and the audio low-pass/decimation chain, with AXI-Stream on both sides.

---
 rtl/fm_phase_discriminator.sv | 131 +++++++++++++
 tb/tb_fm_phase_discriminator.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_phase_discriminator.sv
`default_nettype none
// ============================================================================
// Module      : fm_phase_discriminator
// Description : FM discriminator. Takes a stream of MSB-aligned phase angles
//               and emits the signed phase step between consecutive samples.
//               The steps are averaged over 2^DECIM_LOG2 samples by an
//               integrate-and-dump decimator.
//
//   s00_axis_aclk      in   single clock
//   s00_axis_areset    in   synchronous active-high reset
//   s00_axis_t*        in   angle stream; angle in tdata[31 -: ANGLE_WIDTH]
//   m00_axis_t*        out  frequency stream, sign-extended to 32 bits
//   primed             out  a previous angle is held for differencing
//
// Revision    : 1.0 - initial release
// ============================================================================
module fm_phase_discriminator #(
    parameter int ANGLE_WIDTH = 16,
    parameter int DECIM_LOG2  = 2,
    parameter int GAIN_SHIFT  = 0
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_areset,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic [31:0] s00_axis_tdata,
    input  logic [3:0]  s00_axis_tstrb,
    input  logic        s00_axis_tlast,
    output logic        m00_axis_tvalid,
    input  logic        m00_axis_tready,
    output logic [31:0] m00_axis_tdata,
    output logic [3:0]  m00_axis_tstrb,
    output logic        m00_axis_tlast,
    output logic        primed
);

    // The accumulator carries DECIM_LOG2 guard bits, enough for a full
    // window of worst-case steps.
    localparam int                 c_ACC_W   = ANGLE_WIDTH + DECIM_LOG2;
    localparam int                 c_CNT_W   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'((1 << DECIM_LOG2) - 1);
    localparam int                 c_SHIFT   = DECIM_LOG2 + GAIN_SHIFT;

    logic [ANGLE_WIDTH-1:0]    r_prev;
    logic                      r_primed;
    logic signed [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_tvalid;
    logic [31:0]               r_tdata;
    logic [3:0]                r_tstrb;
    logic                      r_tlast;

    logic [ANGLE_WIDTH-1:0]    w_angle;
    logic signed [ANGLE_WIDTH-1:0] w_diff;
    logic signed [c_ACC_W-1:0] w_acc_base;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic signed [c_ACC_W-1:0] w_scaled;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_dump;
    logic                      w_unused;

    assign w_angle = s00_axis_tdata[31 -: ANGLE_WIDTH];

    // Modular subtraction at the native angle width resolves wrap-around:
    // the result is the shortest signed step around the circle.
    assign w_diff = w_angle - r_prev;

    // A new window starts from zero instead of clearing r_acc on dump.
    assign w_acc_base = (r_cnt == '0) ? '0 : r_acc;
    assign w_acc_next = w_acc_base + c_ACC_W'(w_diff);

    // Windows closed early by tlast are still divided by the full DECIM.
    assign w_scaled = w_acc_next >>> c_SHIFT;

    assign w_dump     = (r_cnt == c_CNT_MAX) || s00_axis_tlast;
    assign w_in_fire  = s00_axis_tvalid && s00_axis_tready;
    assign w_out_fire = r_tvalid && m00_axis_tready;

    assign s00_axis_tready = !r_tvalid || m00_axis_tready;

    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tstrb  = r_tstrb;
    assign m00_axis_tlast  = r_tlast;
    assign primed          = r_primed;

    assign w_unused = ^{s00_axis_tstrb, s00_axis_tdata[31-ANGLE_WIDTH:0]};

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tstrb  <= '0;
            r_tlast  <= 1'b0;
        end else begin
            if (w_out_fire) begin
                r_tvalid <= 1'b0;
            end
            if (w_in_fire) begin
                r_prev <= w_angle;
                if (!r_primed) begin
                    r_primed <= 1'b1;
                end else begin
                    r_acc <= w_acc_next;
                    if (w_dump) begin
                        // Overrides the handshake clear above so a
                        // back-to-back dump keeps tvalid high.
                        r_tdata  <= 32'(w_scaled);
                        r_tvalid <= 1'b1;
                        r_tlast  <= s00_axis_tlast;
                        r_tstrb  <= 4'hF;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                // End of packet: the next packet re-primes on its first beat.
                if (s00_axis_tlast) begin
                    r_primed <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fm_phase_discriminator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_phase_discriminator
// Description : Directed bench for fm_phase_discriminator with a scoreboard
//               pass over a random angle stream under random handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_phase_discriminator;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tready;

    // main instance: DECIM_LOG2=2, GAIN_SHIFT=0
    logic        s_tready, m_tvalid, m_tlast, primed;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    // gain instance: DECIM_LOG2=2, GAIN_SHIFT=2
    logic        g_s_tready, g_tvalid, g_tlast, g_primed;
    logic [31:0] g_tdata;
    logic [3:0]  g_tstrb;
    // no-decimation instance: DECIM_LOG2=0
    logic        d_s_tready, d_tvalid, d_tlast, d_primed;
    logic [31:0] d_tdata;
    logic [3:0]  d_tstrb;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fm_phase_discriminator #(.ANGLE_WIDTH(16), .DECIM_LOG2(2), .GAIN_SHIFT(0)) dut (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'hF), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
        .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast),
        .primed(primed)
    );

    fm_phase_discriminator #(.ANGLE_WIDTH(16), .DECIM_LOG2(2), .GAIN_SHIFT(2)) dut_g (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(g_s_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'h0), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(g_tvalid), .m00_axis_tready(1'b1),
        .m00_axis_tdata(g_tdata), .m00_axis_tstrb(g_tstrb), .m00_axis_tlast(g_tlast),
        .primed(g_primed)
    );

    fm_phase_discriminator #(.ANGLE_WIDTH(16), .DECIM_LOG2(0), .GAIN_SHIFT(0)) dut_d0 (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(d_s_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'h0), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(d_tvalid), .m00_axis_tready(1'b1),
        .m00_axis_tdata(d_tdata), .m00_axis_tstrb(d_tstrb), .m00_axis_tlast(d_tlast),
        .primed(d_primed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One beat presented for exactly one edge; low bits carry junk that
    // the design must ignore.
    task automatic beat(input logic [15:0] a, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = {a, 16'hA5A5};
        s_tlast  = l;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_const(input string tag);
        for (int i = 1; i <= 9; i++) begin
            beat(16'h1000, 1'b0);
            if (i == 1) chk({tag, "_primed"}, {31'd0, primed}, 32'd1);
            chk({tag, "_valid"}, {31'd0, m_tvalid}, {31'd0, (i == 5 || i == 9)});
            if (i == 5 || i == 9) begin
                chk({tag, "_data"}, m_tdata, 32'h0000_0000);
                chk({tag, "_last"}, {31'd0, m_tlast}, 32'd0);
                chk({tag, "_strb"}, {28'd0, m_tstrb}, 32'hF);
            end
        end
    endtask

    // scoreboard state for the random pass
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          m_prev, m_acc, m_cnt, m_ang, m_d;
    bit          m_primed;

    task automatic sb_step();
        logic [31:0] e_data;
        logic        e_last;
        if (m_tvalid && m_tready) begin
            if (q_data.size() == 0) begin
                chk("rand_unexpected_out", m_tdata, 32'hDEAD_BEEF);
            end else begin
                e_data = q_data.pop_front();
                e_last = q_last.pop_front();
                chk("rand_data", m_tdata, e_data);
                chk("rand_last", {31'd0, m_tlast}, {31'd0, e_last});
            end
        end
        if (s_tvalid && s_tready) begin
            m_ang = int'(s_tdata[31:16]);
            if (m_primed) begin
                m_d = m_ang - m_prev;
                if (m_d >= 32768) m_d -= 65536;
                else if (m_d < -32768) m_d += 65536;
                m_acc = ((m_cnt == 0) ? 0 : m_acc) + m_d;
                if (m_cnt == 3 || s_tlast) begin
                    q_data.push_back(32'(m_acc >>> 2));
                    q_last.push_back(s_tlast);
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_primed = 1'b1;
            m_prev   = m_ang;
            if (s_tlast) m_primed = 1'b0;
        end
    endtask

    initial begin
        int beats, cycles;
        s_tdata  = '0;
        m_tready = 1'b1;
        do_reset();
        tick();

        // reset values
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata",  m_tdata, 32'd0);
        chk("rst_tstrb",  {28'd0, m_tstrb}, 32'd0);
        chk("rst_tlast",  {31'd0, m_tlast}, 32'd0);
        chk("rst_primed", {31'd0, primed}, 32'd0);
        chk("rst_tready", {31'd0, s_tready}, 32'd1);

        // constant angle
        run_const("const");

        // phase ramp, with and without gain shift
        do_reset();
        for (int i = 0; i < 9; i++) begin
            beat(16'(i * 16'h0100), 1'b0);
            chk("ramp_valid", {31'd0, m_tvalid}, {31'd0, (i == 4 || i == 8)});
            if (i == 4 || i == 8) begin
                chk("ramp_data", m_tdata, 32'h0000_0100);
                chk("ramp_gain_valid", {31'd0, g_tvalid}, 32'd1);
                chk("ramp_gain_data", g_tdata, 32'h0000_0040);
            end
        end

        // wrap-around, one output per primed beat
        do_reset();
        beat(16'hFFF0, 1'b0);
        chk("wrap_prime_valid", {31'd0, d_tvalid}, 32'd0);
        beat(16'h0010, 1'b0);
        chk("wrap_fwd_valid", {31'd0, d_tvalid}, 32'd1);
        chk("wrap_fwd", d_tdata, 32'h0000_0020);
        beat(16'hFFF0, 1'b0);
        chk("wrap_back", d_tdata, 32'hFFFF_FFE0);
        beat(16'h0000, 1'b0);
        chk("wrap_small", d_tdata, 32'h0000_0010);
        beat(16'h8000, 1'b0);
        chk("wrap_half", d_tdata, 32'hFFFF_8000);

        // partial window closed by tlast
        do_reset();
        beat(16'h0000, 1'b0);
        beat(16'h0040, 1'b0);
        beat(16'h0080, 1'b1);
        chk("part_valid",  {31'd0, m_tvalid}, 32'd1);
        chk("part_data",   m_tdata, 32'h0000_0020);
        chk("part_last",   {31'd0, m_tlast}, 32'd1);
        chk("part_strb",   {28'd0, m_tstrb}, 32'hF);
        chk("part_primed", {31'd0, primed}, 32'd0);
        beat(16'h5000, 1'b0);
        chk("part_next_valid",  {31'd0, m_tvalid}, 32'd0);
        chk("part_next_primed", {31'd0, primed}, 32'd1);

        // backpressure on a held output
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) beat(16'(i * 16'h0100), 1'b0);
        chk("bp_valid", {31'd0, m_tvalid}, 32'd1);
        s_tvalid = 1'b1;
        s_tdata  = {16'h0500, 16'hA5A5};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_tready", {31'd0, s_tready}, 32'd0);
            chk("bp_hold_valid", {31'd0, m_tvalid}, 32'd1);
            chk("bp_hold_data", m_tdata, 32'h0000_0100);
            chk("bp_hold_last", {31'd0, m_tlast}, 32'd0);
        end
        m_tready = 1'b1;
        #1;
        chk("bp_release_tready", {31'd0, s_tready}, 32'd1);
        tick();
        s_tvalid = 1'b0;
        chk("bp_after_hs_valid", {31'd0, m_tvalid}, 32'd0);
        beat(16'h0600, 1'b0);
        beat(16'h0700, 1'b0);
        chk("bp_mid_valid", {31'd0, m_tvalid}, 32'd0);
        beat(16'h0800, 1'b0);
        chk("bp_resume_valid", {31'd0, m_tvalid}, 32'd1);
        chk("bp_resume_data", m_tdata, 32'h0000_0100);

        // random stream against the scoreboard
        do_reset();
        q_data.delete();
        q_last.delete();
        m_prev = 0; m_acc = 0; m_cnt = 0; m_primed = 1'b0;
        beats  = 0;
        cycles = 0;
        while (beats < 1000 && cycles < 20000) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = $urandom;
            s_tlast  = ($urandom_range(0, 15) == 0);
            m_tready = ($urandom_range(0, 3) != 0);
            #1;
            if (s_tvalid && s_tready) beats++;
            sb_step();
            tick();
            cycles++;
        end
        chk("rand_beats_done", 32'(beats), 32'd1000);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            sb_step();
            tick();
        end
        chk("rand_queue_empty", 32'(q_data.size()), 32'd0);

        // reset with an output pending and a window in progress
        do_reset();
        m_tready = 1'b1;
        beat(16'h1000, 1'b0);
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) beat(16'h1000, 1'b0);
        chk("rst_mid_pending", {31'd0, m_tvalid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid",  {31'd0, m_tvalid}, 32'd0);
        chk("rst_mid_data",   m_tdata, 32'd0);
        chk("rst_mid_primed", {31'd0, primed}, 32'd0);
        m_tready = 1'b1;
        run_const("rst_const");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
